// File: rtl/video_pkg.sv
// Shared constants for the 640x480@60 raster and the colour-bar palette.
package video_pkg;

  localparam int   H_ACTIVE_DEF = 640;
  localparam int   H_FP_DEF     = 16;
  localparam int   H_SYNC_DEF   = 96;
  localparam int   H_BP_DEF     = 48;
  localparam int   V_ACTIVE_DEF = 480;
  localparam int   V_FP_DEF     = 10;
  localparam int   V_SYNC_DEF   = 2;
  localparam int   V_BP_DEF     = 33;
  localparam logic HS_POL_DEF   = 1'b0;
  localparam logic VS_POL_DEF   = 1'b0;
  localparam int   CW_DEF       = 10;

  typedef enum logic [2:0] {
    BAR_WHITE, BAR_YELLOW, BAR_CYAN, BAR_GREEN,
    BAR_MAGENTA, BAR_RED, BAR_BLUE, BAR_BLACK
  } bar_e;

  // Returns {R, G, B}; each component is fully on or fully off.
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    logic [23:0] rgb;
    case (bar_e'(idx))
      BAR_WHITE:   rgb = 24'hFF_FF_FF;
      BAR_YELLOW:  rgb = 24'hFF_FF_00;
      BAR_CYAN:    rgb = 24'h00_FF_FF;
      BAR_GREEN:   rgb = 24'h00_FF_00;
      BAR_MAGENTA: rgb = 24'hFF_00_FF;
      BAR_RED:     rgb = 24'hFF_00_00;
      BAR_BLUE:    rgb = 24'h00_00_FF;
      default:     rgb = 24'h00_00_00;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/video_sync_counter.sv
// One raster axis: wrapping position counter with active-region and sync decode.
module video_sync_counter
  import video_pkg::*;
#(
  parameter int   ACTIVE = H_ACTIVE_DEF,
  parameter int   FP     = H_FP_DEF,
  parameter int   SYNC   = H_SYNC_DEF,
  parameter int   BP     = H_BP_DEF,
  parameter logic POL    = HS_POL_DEF,
  parameter int   CW     = CW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o,
  output logic          active_o,
  output logic          sync_o
);

  localparam int            TOTAL    = ACTIVE + FP + SYNC + BP;
  localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END  = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_BEG = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END = CW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign wrap_o   = en_i && (cnt_q == LAST);
  assign active_o = (cnt_q < ACT_END);
  assign sync_o   = ((cnt_q >= SYNC_BEG) && (cnt_q < SYNC_END)) ? POL : ~POL;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with an eight-bar colour pattern; every output is
// taken from one register stage so all of them describe the same pixel.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic HS_POL   = HS_POL_DEF,
  parameter logic VS_POL   = VS_POL_DEF,
  parameter int   CW       = CW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  output logic          dena,
  output logic [1:0]    ctrl,
  output logic          hsync,
  output logic          vsync,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_start
);

  localparam logic [CW-1:0] BAR_LAST = CW'(H_ACTIVE / 8 - 1);

  logic [CW-1:0] hc, vc;
  logic          h_wrap, h_act, v_act, hs, vs;
  logic          v_wrap_unused;

  video_sync_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CW(CW)
  ) u_h (
    .clk(clk), .rstn(rstn), .en_i(1'b1),
    .cnt_o(hc), .wrap_o(h_wrap), .active_o(h_act), .sync_o(hs)
  );

  // Vertical axis advances once per line, so vsync edges land on line starts.
  video_sync_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CW(CW)
  ) u_v (
    .clk(clk), .rstn(rstn), .en_i(h_wrap),
    .cnt_o(vc), .wrap_o(v_wrap_unused), .active_o(v_act), .sync_o(vs)
  );

  logic [CW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]    bar_idx_q, bar_idx_d;

  // bar_idx tracks hc, cleared as hc wraps so it reads 0 at hc = 0.
  always_comb begin
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (h_wrap) begin
      bar_cnt_d = '0;
      bar_idx_d = '0;
    end else if (h_act) begin
      if (bar_cnt_q == BAR_LAST) begin
        bar_cnt_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + CW'(1);
      end
    end
  end

  logic          dena_d, dena_q;
  logic          hsync_q, vsync_q;
  logic [23:0]   rgb_d, rgb_q;
  logic [CW-1:0] x_q, y_q;
  logic          fs_d, fs_q;

  assign dena_d = h_act && v_act;
  assign rgb_d  = dena_d ? bar_rgb(bar_idx_q) : 24'h0;
  assign fs_d   = (hc == '0) && (vc == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      dena_q    <= 1'b0;
      hsync_q   <= ~HS_POL;
      vsync_q   <= ~VS_POL;
      rgb_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      fs_q      <= 1'b0;
    end else begin
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      dena_q    <= dena_d;
      hsync_q   <= hs;
      vsync_q   <= vs;
      rgb_q     <= rgb_d;
      x_q       <= hc;
      y_q       <= vc;
      fs_q      <= fs_d;
    end
  end

  assign dena        = dena_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign ctrl        = {vsync_q, hsync_q};
  assign red         = rgb_q[23:16];
  assign green       = rgb_q[15:8];
  assign blue        = rgb_q[7:0];
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 640x480 build plus a tiny 24x8 raster build side by side.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  // Default build
  logic       d_dena, d_hs, d_vs, d_fs;
  logic [1:0] d_ctrl;
  logic [7:0] d_r, d_g, d_b;
  logic [9:0] d_x, d_y;

  video_timing_gen u_dut (
    .clk(clk), .rstn(rstn), .dena(d_dena), .ctrl(d_ctrl), .hsync(d_hs), .vsync(d_vs),
    .red(d_r), .green(d_g), .blue(d_b), .x(d_x), .y(d_y), .frame_start(d_fs)
  );

  // Small build: line 24 clocks, frame 8 lines, bars 2 pixels wide
  logic       s_dena, s_hs, s_vs, s_fs;
  logic [1:0] s_ctrl;
  logic [7:0] s_r, s_g, s_b;
  logic [9:0] s_x, s_y;

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2), .HS_POL(1'b1)
  ) u_small (
    .clk(clk), .rstn(rstn), .dena(s_dena), .ctrl(s_ctrl), .hsync(s_hs), .vsync(s_vs),
    .red(s_r), .green(s_g), .blue(s_b), .x(s_x), .y(s_y), .frame_start(s_fs)
  );

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];
  logic [23:0] bar_tbl [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_d_dena", 32'(d_dena), 0);
    check("rst_d_fs", 32'(d_fs), 0);
    check("rst_d_x", 32'(d_x), 0);
    check("rst_d_y", 32'(d_y), 0);
    check("rst_d_rgb", 32'({d_r, d_g, d_b}), 0);
    check("rst_d_ctrl", 32'(d_ctrl), 32'b11);
    check("rst_d_hsync", 32'(d_hs), 1);
    check("rst_d_vsync", 32'(d_vs), 1);
    check("rst_s_dena", 32'(s_dena), 0);
    check("rst_s_ctrl", 32'(s_ctrl), 32'b10);
    check("rst_s_x", 32'(s_x), 0);
  endtask

  // Stats gathered over the first 1600 clocks after reset release
  int d_den_l0 = 0, d_den_l1 = 0, d_fall = -1, d_rise = -1;
  int d_hs_first = -1, d_hs_last = -1, d_hs_cnt = 0, d_vs_low = 0, d_fs_cnt = 0;
  int s_fs_cnt = 0, s_fs_second = -1, s_den_f0 = 0, s_hs_hi = 0, s_hs_bad = 0;
  int s_vs_low = 0, s_vs_first = -1, s_vs_first_x = -1;

  initial begin
    step(3);
    check_reset_values();

    for (int x = 0; x < 800; x++) begin
      exp_q.push_back((x < 640) ? bar_tbl[x / 80] : 24'h0);
    end

    rstn = 1'b1;
    step(1);
    check("first_d_dena", 32'(d_dena), 1);
    check("first_d_fs", 32'(d_fs), 1);
    check("first_d_xy", 32'({d_x, d_y}), 0);
    check("first_d_ctrl", 32'(d_ctrl), 32'b11);
    check("first_s_fs", 32'(s_fs), 1);
    check("first_s_ctrl", 32'(s_ctrl), 32'b10);

    for (int p = 0; p < 1600; p++) begin
      if (p < 800) begin
        check("bar_rgb_line0", 32'({d_r, d_g, d_b}), 32'(exp_q.pop_front()));
        if (d_dena) d_den_l0++;
        if (!d_hs) begin
          d_hs_cnt++;
          if (d_hs_first < 0) d_hs_first = p;
          d_hs_last = p;
        end
      end else if (d_dena) begin
        d_den_l1++;
      end
      if (!d_dena && d_fall < 0) d_fall = p;
      if (d_dena && d_fall >= 0 && d_rise < 0) d_rise = p;
      if (!d_vs) d_vs_low++;
      if (d_fs) d_fs_cnt++;
      if (p == 800) check("d_line_period", 32'({d_x, d_y}), 32'({10'd0, 10'd1}));

      if (s_fs) begin
        s_fs_cnt++;
        if (p > 0 && s_fs_second < 0) s_fs_second = p;
      end
      if (p < 192) begin
        if (s_dena) s_den_f0++;
        if (s_hs) s_hs_hi++;
        if (!s_vs) begin
          s_vs_low++;
          if (s_vs_first < 0) begin
            s_vs_first = p;
            s_vs_first_x = int'(s_x);
          end
        end
      end
      if (s_hs && s_x != 10'd18 && s_x != 10'd19) s_hs_bad++;
      if (p == 1)  check("s_bar_white", 32'({s_r, s_g, s_b}), 32'hFFFFFF);
      if (p == 2)  check("s_bar_yellow", 32'({s_r, s_g, s_b}), 32'hFFFF00);
      if (p == 4)  check("s_bar_cyan", 32'({s_r, s_g, s_b}), 32'h00FFFF);
      if (p == 15) check("s_bar_black", 32'({s_r, s_g, s_b, s_dena}), 32'h1);
      if (p == 16) check("s_blank_rgb", 32'({s_r, s_g, s_b, s_dena}), 32'h0);
      if (p == 24) check("s_line_period", 32'({s_x, s_y}), 32'({10'd0, 10'd1}));
      step(1);
    end

    check("d_dena_line0", d_den_l0, 640);
    check("d_dena_line1", d_den_l1, 640);
    check("d_dena_fall", d_fall, 640);
    check("d_hsync_start", d_hs_first, 656);
    check("d_hsync_width", d_hs_cnt, 96);
    check("d_hsync_end", d_hs_last, 751);
    check("d_dena_rise", d_rise, 800);
    check("d_vsync_idle", d_vs_low, 0);
    check("d_fs_count", d_fs_cnt, 1);
    check("s_fs_count", s_fs_cnt, 9);
    check("s_frame_period", s_fs_second, 192);
    check("s_dena_frame", s_den_f0, 64);
    check("s_hsync_high", s_hs_hi, 16);
    check("s_hsync_pos", s_hs_bad, 0);
    check("s_vsync_width", s_vs_low, 24);
    check("s_vsync_start", s_vs_first, 120);
    check("s_vsync_at_x0", s_vs_first_x, 0);

    // Mid-frame reset at line 3, pixel 100
    step(900);
    check("pre_rst_xy", 32'({d_x, d_y}), 32'({10'd100, 10'd3}));
    check("pre_rst_dena", 32'(d_dena), 1);
    rstn = 1'b0;
    #2;
    check_reset_values();
    step(2);
    check("hold_rst_x", 32'(d_x), 0);
    rstn = 1'b1;
    step(1);
    check("restart_d_fs", 32'(d_fs), 1);
    check("restart_d_xy", 32'({d_x, d_y}), 0);
    check("restart_d_rgb", 32'({d_r, d_g, d_b, d_dena}), 32'h1FFFFFF);
    check("restart_s_fs", 32'({s_fs, s_x}), 32'({1'b1, 10'd0}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Pixel-clock-domain raster timing generator with a colour-bar pattern source. It drives the three TMDS encoder channels upstream of them.
- Produces dena, the channel-0 control pair ctrl = {vsync, hsync} and 8-bit R/G/B pixel data.
- All outputs come from one register stage, so every output refers to the same pixel.
- Defaults give 640x480@60 (25.175 MHz pixel clock).

Parameters:
- H_ACTIVE, 640, visible pixels per line; must be a multiple of 8.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BP, 33, vertical back porch in lines.
- HS_POL, 0, active level of hsync.
- VS_POL, 0, active level of vsync.
- CW, 10, width of the x/y coordinate counters; must satisfy 2^CW >= H_TOTAL and 2^CW >= V_TOTAL.

Ports:
- clk  in  1  pixel clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- dena  out  1  data enable, high for active pixels.
- ctrl  out  2  {vsync, hsync} at their configured polarity; feeds the blue-channel encoder ctrl input.
- hsync  out  1  horizontal sync, same value as ctrl[0].
- vsync  out  1  vertical sync, same value as ctrl[1].
- red  out  8  pixel red component.
- green  out  8  pixel green component.
- blue  out  8  pixel blue component.
- x  out  CW  horizontal position of the current output pixel.
- y  out  CW  vertical position of the current output pixel.
- frame_start  out  1  one-cycle pulse accompanying pixel (0,0).

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525); BAR_W = H_ACTIVE/8 (80).
- Counter hc: counts 0..H_TOTAL-1 every cycle and wraps to 0.
- Counter vc: increments only when hc = H_TOTAL-1; wraps to 0 when vc = V_TOTAL-1 on that same cycle.
- Active region: hc < H_ACTIVE and vc < V_ACTIVE.
- hsync asserted while H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
- vsync asserted while V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, for entire lines.
- vsync changes in the same cycle as hc leaves H_TOTAL-1, i.e. aligned to the line start.
- Bar generator:
  - bar_cnt and bar_idx[2:0] reset to 0 at hc = 0.
  - bar_cnt counts within the active region; at BAR_W-1 it returns to 0 and bar_idx increments.
  - No divider is used.
- Bar colours by bar_idx, with {R,G,B} each 8'hFF or 8'h00: 0 white, 1 yellow, 2 cyan, 3 green, 4 magenta, 5 red, 6 blue, 7 black.
- Latency:
  - Outputs register the combinational decode of (hc, vc, bar_idx) from the same cycle, so they lag the counters by exactly 1 clock.
  - dena, ctrl, hsync, vsync, RGB, x, y and frame_start are mutually aligned.
- Blanking: outside the active region, red/green/blue = 0 and x/y hold the raw counter values (not masked).
- frame_start: high when the registered (hc, vc) = (0, 0).
- Reset (asynchronous, while rstn = 0):
  - hc, vc, bar_cnt, bar_idx all 0.
  - dena = 0, RGB = 0, x = 0, y = 0, frame_start = 0.
  - hsync = ~HS_POL, vsync = ~VS_POL, ctrl = {~VS_POL, ~HS_POL}.
- After reset release: the first rising edge registers pixel (0,0), giving dena = 1, frame_start = 1, RGB = white.
- Reset asserted mid-frame: outputs go to their reset values immediately, without waiting for a clock edge. After release, the next frame starts from (0,0); no partial-frame resume.
- Counters never exceed TOTAL-1. No out-of-range state is reachable.

Decomposition:
- Shared package video_pkg:
  - 640x480@60 timing constants (H/V active, porches, sync widths, polarities).
  - The 3-bit bar-colour code to RGB mapping.
- One natural sub-module: video_sync_counter.
  - Parameterised (ACTIVE, FP, SYNC, BP, POL).
  - Holds one axis counter with wrap, an increment enable input, an active flag and a sync output.
  - Instantiated twice: horizontal with enable tied 1; vertical with enable = horizontal wrap.
- The bar generator and output register stay in the top module.

Test Plan:
- Reset, then release rstn; defaults -> first edge: dena=1, frame_start=1, x=0, y=0, RGB=FF/FF/FF, ctrl=2'b11.
- Count dena-high cycles per line and per frame (defaults) -> 640 per line; 480 lines with dena; 307200 active pixels per frame; line period 800 clocks; frame period 420000 clocks.
- hsync timing (defaults) -> hsync=0 for exactly 96 clocks starting 16 clocks after dena falls; 48 clocks of blanking before dena rises again.
- vsync timing -> vsync=0 for exactly 2 lines (1600 clocks) beginning at the start of line 490; it changes in the same cycle hsync's line boundary passes (x goes 799->0).
- Colour bars, line 0 -> x=0..79 white, 80..159 yellow (FF,FF,00), 160..239 cyan (00,FF,FF), 560..639 black; x=640..799 RGB=0.
- Reset mid-frame at line 200 -> all outputs at reset values asynchronously (without a clock edge). After release, frame_start pulses on the first edge and x=0, y=0.
- Small-parameter build H_ACTIVE=16, H_FP=2, H_SYNC=2, H_BP=4, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=2, HS_POL=1 -> line 24 clocks, frame 192 clocks, bars 2 pixels wide, hsync high at x=18,19.
